// File: rtl/blk_377c92.sv
// Per-column multiply-accumulate engine: serially loaded operand memory, registered product, accumulator, registered out.
// Optional macro BLOCK_SIGNED_EN selects two's complement operands and a sign-extended product.
module blk_377c92 #(
  parameter  int elementsNum = 4,
  parameter  int dataWidth   = 4,
  localparam int AW          = $clog2(elementsNum),
  localparam int OW          = 2 * dataWidth + AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 zero_in,
  input  logic                 we_out,
  input  logic                 we_mem,
  input  logic [AW-1:0]        wraddr,
  input  logic [dataWidth-1:0] in,
  input  logic [AW-1:0]        rdaddr,
  output logic [OW-1:0]        out
);

  localparam int PW = 2 * dataWidth;

  logic [elementsNum*dataWidth-1:0] mem_flat;
  logic [dataWidth-1:0]             rd_data;

  // Addresses beyond the last entry decode to no entry, so such writes are dropped.
  for (genvar gi = 0; gi < elementsNum; gi++) begin : gen_mem
    logic [dataWidth-1:0] ent_d;
    logic [dataWidth-1:0] ent_q;

    always_comb begin
      ent_d = ent_q;
      if (we_mem && (wraddr == AW'(gi))) begin
        ent_d = in;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ent_q <= '0;
      end else begin
        ent_q <= ent_d;
      end
    end

    assign mem_flat[gi*dataWidth +: dataWidth] = ent_q;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < elementsNum; i++) begin
      if (rdaddr == AW'(i)) begin
        rd_data = mem_flat[i*dataWidth +: dataWidth];
      end
    end
  end

  logic [PW-1:0] in_ext;
  logic [PW-1:0] op_ext;
  logic [OW-1:0] prod_ext;
  logic [PW-1:0] prod_d, prod_q;
  logic          en_d, en_q;
  logic          clr_d, clr_q;
  logic [OW-1:0] acc_d, acc_q;
  logic [OW-1:0] out_d, out_q;

  // The low PW bits of a PW x PW product are the same for signed and unsigned operands.
  always_comb begin
`ifdef BLOCK_SIGNED_EN
    in_ext   = {{dataWidth{in[dataWidth-1]}}, in};
    op_ext   = {{dataWidth{rd_data[dataWidth-1]}}, rd_data};
    prod_ext = {{(OW-PW){prod_q[PW-1]}}, prod_q};
`else
    in_ext   = {{dataWidth{1'b0}}, in};
    op_ext   = {{dataWidth{1'b0}}, rd_data};
    prod_ext = {{(OW-PW){1'b0}}, prod_q};
`endif
    prod_d = in_ext * op_ext;
    en_d   = we_out;
    clr_d  = zero_in;
  end

  always_comb begin
    acc_d = acc_q;
    case ({clr_q, en_q})
      2'b11:   acc_d = prod_ext;
      2'b10:   acc_d = '0;
      2'b01:   acc_d = acc_q + prod_ext;
      default: acc_d = acc_q;
    endcase
    out_d = acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      acc_q  <= '0;
      out_q  <= '0;
    end else begin
      prod_q <= prod_d;
      en_q   <= en_d;
      clr_q  <= clr_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_blk_377c92.sv
// Directed bench for blk_377c92: arithmetic reference model checked every cycle plus literal anchors.
module tb_blk_377c92;

  localparam int OW = 11;

  logic          clk;
  logic          rst;
  logic          zero_in;
  logic          we_out;
  logic          we_mem;
  logic [1:0]    wraddr;
  logic [3:0]    in;
  logic [1:0]    rdaddr;
  logic [OW-1:0] out;

  int checks   = 0;
  int failures = 0;

  blk_377c92 #(.elementsNum(4), .dataWidth(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .zero_in (zero_in),
    .we_out  (we_out),
    .we_mem  (we_mem),
    .wraddr  (wraddr),
    .in      (in),
    .rdaddr  (rdaddr),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model: accumulator value right after each edge; out lags it by one edge.
  logic [OW-1:0] hist   [0:1023];
  bit            rst_at [0:1023];
  logic [3:0]    mem_m  [0:3];
  int            ref_acc   = 0;
  int            first_rst = -1;

  function automatic int opv(logic [3:0] v);
    int r;
    r = int'(v);
`ifdef BLOCK_SIGNED_EN
    if (v[3]) r = r - 16;
`endif
    return r;
  endfunction

  task automatic drive(input bit r, input bit zi, input bit wo, input bit wm,
                       input int wa, input logic [3:0] d, input int ra);
    int k;
    int p;
    @(negedge clk);
    rst = r; zero_in = zi; we_out = wo; we_mem = wm;
    wraddr = 2'(wa); in = d; rdaddr = 2'(ra);
    k = edge_n + 1;
    if (r) begin
      if (first_rst < 0) first_rst = k;
      ref_acc = 0;
      for (int i = 0; i < 4; i++) mem_m[i] = 4'd0;
      rst_at[k] = 1'b1;
    end else begin
      rst_at[k] = 1'b0;
      p = opv(d) * opv(mem_m[ra]);
      if (zi) ref_acc = wo ? p : 0;
      else if (wo) ref_acc = ref_acc + p;
      ref_acc = ref_acc & 2047;
      if (wm && wa < 4) mem_m[wa] = d;
    end
    hist[k] = ref_acc[OW-1:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 4'd0, 0);
  endtask

  task automatic chk(input string name, input logic [OW-1:0] exp);
    checks++;
    if (out !== exp) begin
      failures++;
      $display("FAIL %s out=%0d expected=%0d", name, out, exp);
    end else begin
      $display("ok   %s out=%0d", name, out);
    end
  endtask

  task automatic load(input logic [3:0] a0, input logic [3:0] a1,
                      input logic [3:0] a2, input logic [3:0] a3);
    drive(0, 0, 0, 1, 0, a0, 0);
    drive(0, 0, 0, 1, 1, a1, 0);
    drive(0, 0, 0, 1, 2, a2, 0);
    drive(0, 0, 0, 1, 3, a3, 0);
  endtask

  // Compare every cycle once a reset has been applied.
  always @(negedge clk) begin
    logic [OW-1:0] exp;
    if (first_rst >= 0 && edge_n >= first_rst && edge_n >= 2 && edge_n < 1024) begin
      exp = (rst_at[edge_n] || rst_at[edge_n-1]) ? '0 : hist[edge_n-2];
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL cycle_out edge=%0d out=%0d expected=%0d", edge_n, out, exp);
      end
    end
  end

  initial begin
    rst = 1'b1; zero_in = 1'b0; we_out = 1'b0; we_mem = 1'b0;
    wraddr = '0; in = '0; rdaddr = '0;

    drive(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
          4'($urandom), $urandom_range(0, 3));
    idle(1);
    chk("reset_out", 11'd0);

    for (int i = 0; i < 4; i++) drive(0, i == 0, 1, 0, 0, 4'd5, i);
    idle(3);
    chk("reset_mem_zero", 11'd0);

    load(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 4; i++) drive(0, i == 0, 1, 0, 0, 4'(5 + i), i);
    idle(3);
`ifndef BLOCK_SIGNED_EN
    chk("dot_70", 11'd70);
    idle(2);
    chk("hold_70", 11'd70);
`endif
    drive(0, 1, 0, 0, 0, 4'd3, 1);
    idle(3);
    chk("clear", 11'd0);

    // Same-cycle write and read of entry 0: product uses the old value 1.
    drive(0, 1, 1, 1, 0, 4'd9, 0);
    idle(3);
`ifndef BLOCK_SIGNED_EN
    chk("read_before_write", 11'd9);
`endif
    drive(0, 1, 1, 0, 0, 4'd1, 0);
    idle(3);
`ifndef BLOCK_SIGNED_EN
    chk("new_mem0", 11'd9);
`endif

    load(4'd15, 4'd15, 4'd15, 4'd15);
    for (int i = 0; i < 4; i++) drive(0, i == 0, 1, 0, 0, 4'd15, i);
    idle(3);
`ifndef BLOCK_SIGNED_EN
    chk("max_900", 11'd900);
    checks++;
    if (out[10] !== 1'b0) begin
      failures++;
      $display("FAIL max_msb out10=%b expected=0", out[10]);
    end
    // Six more products without clear: 10*225 = 2250 wraps to 202.
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0, 4'd15, i % 4);
    idle(3);
    chk("wrap_202", 11'd202);
`endif

    load(4'd1, 4'd2, 4'd3, 4'd4);
    drive(0, 1, 1, 0, 0, 4'd5, 0);
    drive(0, 0, 1, 0, 0, 4'd6, 1);
    drive(1, 0, 1, 1, 2, 4'd7, 2);
    idle(1);
    chk("reset_mid_run", 11'd0);
    for (int i = 0; i < 4; i++) drive(0, i == 0, 1, 0, 0, 4'd5, i);
    idle(3);
    chk("reset_mem_cleared", 11'd0);

`ifdef BLOCK_SIGNED_EN
    drive(0, 0, 0, 1, 0, 4'hF, 0);
    drive(0, 1, 1, 0, 0, 4'h7, 0);
    idle(3);
    chk("signed_minus7", 11'h7F9);
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
